// File: rtl/laser_timer_multi.sv
// Multi-channel hold-and-tail LED/laser controller: each output follows its button and then
// stays lit for TAIL_LEN prescaled ticks after release.
module laser_timer_multi #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned TAIL_LEN = 2,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                oneshot,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] done,
   output logic                busy
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = (TAIL_LEN > 0) ? $clog2(TAIL_LEN + 1) : 1;
   localparam logic [PW-1:0] PreMax   = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] TailInit = (TAIL_LEN > 0) ? CW'(TAIL_LEN - 1) : '0;

   typedef enum logic [1:0] {StOff, StHeld, StTail} state_e;

   logic [PW-1:0]       pre_q, pre_d;
   logic                tick;
   state_e              state_q [CHANNELS];
   state_e              state_d [CHANNELS];
   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];
   logic [CHANNELS-1:0] led_q, led_d;
   logic [CHANNELS-1:0] done_q, done_d;

   // Shared prescaler keeps running through clr so tick phase only depends on reset.
   always_comb begin
      tick  = (pre_q == PreMax);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         done_d[i]  = 1'b0;
         if (clr) begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
         end else begin
            unique case (state_q[i])
               StOff: begin
                  if (btn[i]) state_d[i] = StHeld;
               end
               StHeld: begin
                  if (!btn[i]) begin
                     if (TAIL_LEN > 0) begin
                        state_d[i] = StTail;
                        cnt_d[i]   = TailInit;
                     end else begin
                        state_d[i] = StOff;
                        done_d[i]  = 1'b1;
                     end
                  end
               end
               StTail: begin
                  if (btn[i] && !oneshot) begin
                     state_d[i] = StHeld;
                  end else if (tick) begin
                     if (cnt_q[i] == '0) begin
                        state_d[i] = StOff;
                        done_d[i]  = 1'b1;
                     end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                     end
                  end
               end
               default: begin
                  state_d[i] = StOff;
                  cnt_d[i]   = '0;
               end
            endcase
         end
         led_d[i] = (state_d[i] != StOff);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         led_q  <= '0;
         done_q <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i] <= StOff;
            cnt_q[i]   <= '0;
         end
      end else begin
         pre_q  <= pre_d;
         led_q  <= led_d;
         done_q <= done_d;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         busy = busy | (state_q[i] != StOff);
      end
   end

   assign led  = led_q;
   assign done = done_q;

endmodule

// File: tb/tb_laser_timer_multi.sv
// Scoreboard bench for laser_timer_multi: three configurations share one stimulus stream and
// are checked against a tick-counting reference model.
module tb_laser_timer_multi;

   localparam int NCFG = 3;
   localparam int CH   = 4;

   function automatic int tl_of(int k);
      case (k)
         0:       return 2;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int div_of(int k);
      case (k)
         0:       return 1;
         1:       return 4;
         default: return 2;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          oneshot = 1'b0;
   logic [CH-1:0] btn = '1;
   logic [CH-1:0] led_a, led_b, led_c, done_a, done_b, done_c;
   logic          busy_a, busy_b, busy_c;

   logic [NCFG-1:0][CH-1:0] led_act, done_act;
   logic [NCFG-1:0]         busy_act;
   assign led_act  = {led_c, led_b, led_a};
   assign done_act = {done_c, done_b, done_a};
   assign busy_act = {busy_c, busy_b, busy_a};

   laser_timer_multi #(.CHANNELS(CH), .TAIL_LEN(2), .TICK_DIV(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .oneshot(oneshot), .btn(btn),
      .led(led_a), .done(done_a), .busy(busy_a));
   laser_timer_multi #(.CHANNELS(CH), .TAIL_LEN(3), .TICK_DIV(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .oneshot(oneshot), .btn(btn),
      .led(led_b), .done(done_b), .busy(busy_b));
   laser_timer_multi #(.CHANNELS(CH), .TAIL_LEN(0), .TICK_DIV(2)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .oneshot(oneshot), .btn(btn),
      .led(led_c), .done(done_c), .busy(busy_c));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(string name, int k, logic [CH-1:0] got, logic [CH-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s cfg%0d at %0t: got %b want %b", name, k, $time, got, want);
      end
   endtask

   // Reference model: a channel is lit, optionally in its tail with a number of ticks left.
   bit lit  [NCFG][CH];
   bit tail [NCFG][CH];
   int rem  [NCFG][CH];
   int edges;

   typedef struct packed {
      logic [NCFG-1:0][CH-1:0] led;
      logic [NCFG-1:0][CH-1:0] done;
      logic [NCFG-1:0]         busy;
   } exp_t;
   exp_t sb_q[$];

   task automatic model_reset();
      for (int k = 0; k < NCFG; k++) begin
         for (int c = 0; c < CH; c++) begin
            lit[k][c]  = 1'b0;
            tail[k][c] = 1'b0;
            rem[k][c]  = 0;
         end
      end
      edges = 0;
   endtask

   always @(negedge rst_n) begin
      model_reset();
      sb_q.delete();
   end

   always @(posedge clk) begin
      exp_t e;
      bit   tk;
      bit   dn;
      if (rst_n) begin
         e = '0;
         for (int k = 0; k < NCFG; k++) begin
            tk = ((edges % div_of(k)) == div_of(k) - 1);
            for (int c = 0; c < CH; c++) begin
               dn = 1'b0;
               if (clr) begin
                  lit[k][c]  = 1'b0;
                  tail[k][c] = 1'b0;
               end else if (!lit[k][c]) begin
                  if (btn[c]) lit[k][c] = 1'b1;
               end else if (!tail[k][c]) begin
                  if (!btn[c]) begin
                     if (tl_of(k) > 0) begin
                        tail[k][c] = 1'b1;
                        rem[k][c]  = tl_of(k);
                     end else begin
                        lit[k][c] = 1'b0;
                        dn        = 1'b1;
                     end
                  end
               end else if (btn[c] && !oneshot) begin
                  tail[k][c] = 1'b0;
               end else if (tk) begin
                  rem[k][c]--;
                  if (rem[k][c] == 0) begin
                     lit[k][c]  = 1'b0;
                     tail[k][c] = 1'b0;
                     dn         = 1'b1;
                  end
               end
               e.led[k][c]  = lit[k][c];
               e.done[k][c] = dn;
               e.busy[k]    = e.busy[k] | lit[k][c];
            end
         end
         edges++;
         sb_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         for (int k = 0; k < NCFG; k++) begin
            check("led", k, led_act[k], e.led[k]);
            check("done", k, done_act[k], e.done[k]);
            check("busy", k, {3'b0, busy_act[k]}, {3'b0, e.busy[k]});
         end
      end
   end

   task automatic next(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_idle(string name);
      for (int k = 0; k < NCFG; k++) begin
         check({name, "_led"}, k, led_act[k], '0);
         check({name, "_done"}, k, done_act[k], '0);
         check({name, "_busy"}, k, {3'b0, busy_act[k]}, '0);
      end
   endtask

   initial begin
      model_reset();
      #12;
      check_idle("rst");
      next();
      rst_n = 1'b1;
      next(2);
      btn = '0;
      next(10);

      // Legacy timing on channel 0.
      btn = 4'b0001;
      next(3);
      btn = '0;
      next(10);

      // Single-cycle pulses at varying prescaler phases.
      for (int i = 0; i < 4; i++) begin
         btn = 4'b0001;
         next();
         btn = '0;
         next(16 + i);
      end

      // Re-press one cycle into the tail, both modes.
      for (int m = 0; m < 2; m++) begin
         oneshot = (m == 1);
         btn = 4'b0001;
         next(2);
         btn = '0;
         next();
         btn = 4'b0001;
         next((m == 1) ? 20 : 3);
         btn = '0;
         next(20);
      end
      oneshot = 1'b0;

      // Clear with ch0/ch2 in tail and ch1 held, then new presses.
      btn = 4'b0111;
      next(2);
      btn = 4'b0010;
      next();
      clr = 1'b1;
      next();
      clr = 1'b0;
      btn = 4'b0101;
      next(3);
      btn = '0;
      next(20);

      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 3) == 0) btn[c] = ~btn[c];
         end
         clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 19) == 0) oneshot = ~oneshot;
         next();
      end
      clr = 1'b0;
      oneshot = 1'b0;

      // Asynchronous reset dropped between edges while channels are in the tail.
      btn = '1;
      next(2);
      btn = '0;
      next();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("arst");
      next();
      rst_n = 1'b1;
      next(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
